riscv_prefetch_ctrl: RTL and testbench

Instruction-side fetch controller that produces the word stream consumed by the core's fetch FIFO. It issues word-aligned requests on the instruction-memory request/grant/rvalid bus and forwards each returned word to the FIFO as a valid/addr/rdata push. It also handles branch redirects, hardware-loop redirects and the discarding of responses that are in flight when a redirect occurs. It sits between the instruction memory port and the fetch FIFO in the IF stage.

---
 rtl/riscv_if_pkg.sv | 14 +
 rtl/riscv_prefetch_ctrl.sv | 130 +++++++++++++
 tb/tb_riscv_prefetch_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_if_pkg.sv
// Shared IF-stage definitions: prefetch FSM state encoding and fetch address constants.
package riscv_if_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    WAIT_ABORT  = 2'd3
  } prefetch_state_e;

  localparam logic [31:0] WORD_INC   = 32'h0000_0004;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/riscv_prefetch_ctrl.sv
// Instruction prefetch controller: single-outstanding request/grant/rvalid fetcher
// feeding the fetch FIFO, with branch and hardware-loop redirects.
module riscv_prefetch_ctrl
  import riscv_if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_jump_i,
  input  logic [31:0] hwlp_target_i,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_is_hwlp_o,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  prefetch_state_e state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     rsp_addr_q, rsp_addr_d;
  logic [31:0]     tgt_addr_q, tgt_addr_d;
  logic            first_q, first_d;
  logic            hwlp_q, hwlp_d;
  logic            abort_q, abort_d;

  logic            redirect;
  logic [31:0]     redir_tgt;
  logic            idle_like;
  logic            req;
  logic [31:0]     req_addr;
  logic            grant;
  logic            push;

  assign redirect  = branch_i | hwlp_jump_i;
  assign redir_tgt = branch_i ? branch_addr_i : hwlp_target_i;

  // A response arriving in WAIT_RVALID/WAIT_ABORT frees the single slot, so
  // that cycle may already issue the next request exactly as IDLE would.
  assign idle_like = (state_q == IDLE) ||
                     (((state_q == WAIT_RVALID) || (state_q == WAIT_ABORT)) && instr_rvalid_i);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    req_addr = fetch_addr_q;
    if (idle_like) begin
      req     = fetch_en_i & fifo_ready_i & ~redirect;
      state_d = req ? (instr_gnt_i ? WAIT_RVALID : WAIT_GNT) : IDLE;
    end else if (state_q == WAIT_GNT) begin
      // Address was captured when the request was raised; a redirect here must not move it.
      req      = 1'b1;
      req_addr = rsp_addr_q;
      if (instr_gnt_i) state_d = (abort_q | redirect) ? WAIT_ABORT : WAIT_RVALID;
    end else if (state_q == WAIT_RVALID) begin
      if (redirect) state_d = WAIT_ABORT;
    end
  end

  assign grant = req & instr_gnt_i;
  assign push  = (state_q == WAIT_RVALID) & instr_rvalid_i & ~redirect;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    rsp_addr_d   = req ? req_addr : rsp_addr_q;
    tgt_addr_d   = tgt_addr_q;
    first_d      = first_q;
    hwlp_d       = hwlp_q;
    abort_d      = abort_q;

    if (grant)                                abort_d = 1'b0;
    else if ((state_q == WAIT_GNT) && redirect) abort_d = 1'b1;

    // fetch_addr always holds the next word to request; it advances on grant.
    if (redirect) begin
      fetch_addr_d = redir_tgt & ALIGN_MASK;
      tgt_addr_d   = redir_tgt;
      first_d      = 1'b1;
      hwlp_d       = hwlp_jump_i & ~branch_i;
    end else begin
      if (grant && !abort_q) fetch_addr_d = req_addr + WORD_INC;
      if (push) begin
        first_d = 1'b0;
        hwlp_d  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ADDR & ALIGN_MASK;
      rsp_addr_q   <= '0;
      tgt_addr_q   <= '0;
      first_q      <= 1'b0;
      hwlp_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      rsp_addr_q   <= rsp_addr_d;
      tgt_addr_q   <= tgt_addr_d;
      first_q      <= first_d;
      hwlp_q       <= hwlp_d;
      abort_q      <= abort_d;
    end
  end

  assign instr_req_o    = req;
  assign instr_addr_o   = req ? req_addr : '0;
  assign fifo_valid_o   = push;
  assign fifo_addr_o    = push ? (first_q ? tgt_addr_q : rsp_addr_q) : '0;
  assign fifo_rdata_o   = push ? instr_rdata_i : '0;
  assign fifo_is_hwlp_o = push & hwlp_q;
  assign fifo_clear_o   = branch_i;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// Directed self-checking bench for riscv_prefetch_ctrl with a hand-driven memory bus.
module tb_riscv_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en_i, branch_i, hwlp_jump_i, fifo_ready_i;
  logic [31:0] branch_addr_i, hwlp_target_i;
  logic        fifo_valid_o, fifo_is_hwlp_o, fifo_clear_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, busy_o;
  logic [31:0] instr_addr_o, instr_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_prefetch_ctrl #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en_i     (fetch_en_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .hwlp_jump_i    (hwlp_jump_i),
    .hwlp_target_i  (hwlp_target_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_is_hwlp_o (fifo_is_hwlp_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_clear_o   (fifo_clear_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic gnt, input logic rv, input logic [31:0] rd);
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    #3;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_en_i = 0; branch_i = 0; hwlp_jump_i = 0; fifo_ready_i = 0;
    branch_addr_i = 0; hwlp_target_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0;
    #12;
    check("rst_req", instr_req_o, 0);
    check("rst_addr", instr_addr_o, 0);
    check("rst_valid", fifo_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_clear", fifo_clear_o, 0);
    rst_n = 1'b1;
    tick();

    // Boot fetch, grant in the request cycle, back-to-back responses.
    fetch_en_i = 1; fifo_ready_i = 1;
    bus(1, 0, 0);
    check("boot_req", instr_req_o, 1);
    check("boot_addr", instr_addr_o, 32'h80);
    check("boot_busy", busy_o, 0);
    tick();
    bus(1, 1, 32'h0000_0013);
    check("p0_valid", fifo_valid_o, 1);
    check("p0_addr", fifo_addr_o, 32'h80);
    check("p0_rdata", fifo_rdata_o, 32'h13);
    check("p0_hwlp", fifo_is_hwlp_o, 0);
    check("b2b_addr", instr_addr_o, 32'h84);
    check("b2b_busy", busy_o, 1);
    tick();
    bus(0, 1, 32'h0000_0093);
    check("p1_valid", fifo_valid_o, 1);
    check("p1_addr", fifo_addr_o, 32'h84);
    check("p1_rdata", fifo_rdata_o, 32'h93);
    check("p2_req", instr_req_o, 1);
    check("p2_addr", instr_addr_o, 32'h88);
    tick();

    // Grant withheld: request and address must hold.
    for (int i = 0; i < 2; i++) begin
      bus(0, 0, 0);
      check("wg_req", instr_req_o, 1);
      check("wg_addr", instr_addr_o, 32'h88);
      check("wg_valid", fifo_valid_o, 0);
      tick();
    end
    bus(1, 0, 0);
    check("wg_gnt_addr", instr_addr_o, 32'h88);
    tick();

    // Branch while waiting for rvalid: flush, drop the old response.
    branch_i = 1; branch_addr_i = 32'h1002;
    bus(0, 0, 0);
    check("br_clear", fifo_clear_o, 1);
    check("br_req", instr_req_o, 0);
    tick();
    branch_i = 0;
    bus(1, 1, 32'hDEAD_BEEF);
    check("ab_drop", fifo_valid_o, 0);
    check("ab_clear", fifo_clear_o, 0);
    check("ab_req", instr_req_o, 1);
    check("ab_addr", instr_addr_o, 32'h1000);
    tick();
    bus(1, 1, 32'h11);
    check("br_push", fifo_valid_o, 1);
    check("br_push_addr", fifo_addr_o, 32'h1002);
    check("br_next_addr", instr_addr_o, 32'h1004);
    tick();

    // Branch in the rvalid cycle.
    branch_i = 1; branch_addr_i = 32'h2006;
    bus(0, 1, 32'h22);
    check("brrv_valid", fifo_valid_o, 0);
    check("brrv_req", instr_req_o, 0);
    check("brrv_clear", fifo_clear_o, 1);
    tick();
    branch_i = 0;
    bus(1, 0, 0);
    check("brrv_next_addr", instr_addr_o, 32'h2004);
    tick();

    // Hardware-loop jump: no flush, first push flagged.
    hwlp_jump_i = 1; hwlp_target_i = 32'h200;
    bus(0, 1, 32'h33);
    check("hw_clear", fifo_clear_o, 0);
    check("hw_valid", fifo_valid_o, 0);
    check("hw_req", instr_req_o, 0);
    tick();
    hwlp_jump_i = 0;
    bus(1, 0, 0);
    check("hw_addr", instr_addr_o, 32'h200);
    tick();
    bus(1, 1, 32'h44);
    check("hw_push_addr", fifo_addr_o, 32'h200);
    check("hw_push_flag", fifo_is_hwlp_o, 1);
    check("hw_next_addr", instr_addr_o, 32'h204);
    tick();

    // Branch and hwlp together: branch wins.
    branch_i = 1; branch_addr_i = 32'h3000; hwlp_jump_i = 1; hwlp_target_i = 32'h400;
    bus(0, 1, 32'h55);
    check("both_valid", fifo_valid_o, 0);
    check("both_clear", fifo_clear_o, 1);
    tick();
    branch_i = 0; hwlp_jump_i = 0;
    bus(1, 0, 0);
    check("both_addr", instr_addr_o, 32'h3000);
    tick();

    // FIFO full: response still pushed, no new request.
    fifo_ready_i = 0;
    bus(0, 1, 32'h66);
    check("full_push", fifo_valid_o, 1);
    check("full_push_addr", fifo_addr_o, 32'h3000);
    check("full_hwlp", fifo_is_hwlp_o, 0);
    check("full_req", instr_req_o, 0);
    tick();
    bus(0, 0, 0);
    check("full_idle_req", instr_req_o, 0);
    check("full_idle_busy", busy_o, 0);
    tick();

    // Fetch disabled with a transaction outstanding.
    fifo_ready_i = 1;
    bus(1, 0, 0);
    check("fe_addr", instr_addr_o, 32'h3004);
    tick();
    fetch_en_i = 0;
    bus(0, 0, 0);
    check("fe_wait_req", instr_req_o, 0);
    tick();
    bus(0, 1, 32'h77);
    check("fe_push", fifo_valid_o, 1);
    check("fe_push_addr", fifo_addr_o, 32'h3004);
    check("fe_req", instr_req_o, 0);
    tick();

    // Address wrap at the top of memory.
    fetch_en_i = 1; branch_i = 1; branch_addr_i = 32'hFFFF_FFFC;
    bus(0, 0, 0);
    check("wr_req", instr_req_o, 0);
    tick();
    branch_i = 0;
    bus(1, 0, 0);
    check("wr_addr", instr_addr_o, 32'hFFFF_FFFC);
    tick();
    bus(1, 1, 32'h88);
    check("wr_push_addr", fifo_addr_o, 32'hFFFF_FFFC);
    check("wr_next_addr", instr_addr_o, 32'h0);
    tick();
    bus(0, 1, 32'h99);
    check("wr_push2_addr", fifo_addr_o, 32'h0);
    tick();

    // Redirect while waiting for grant: address held, response discarded.
    bus(0, 0, 0);
    check("rg_req", instr_req_o, 1);
    check("rg_addr", instr_addr_o, 32'h4);
    tick();
    branch_i = 1; branch_addr_i = 32'h500;
    bus(0, 0, 0);
    check("rg_hold_req", instr_req_o, 1);
    check("rg_hold_addr", instr_addr_o, 32'h4);
    tick();
    branch_i = 0;
    bus(1, 0, 0);
    check("rg_gnt_addr", instr_addr_o, 32'h4);
    tick();
    bus(1, 1, 32'hAA);
    check("rg_drop", fifo_valid_o, 0);
    check("rg_new_addr", instr_addr_o, 32'h500);
    tick();
    fetch_en_i = 0;
    bus(0, 1, 32'hBB);
    check("rg_push", fifo_valid_o, 1);
    check("rg_push_addr", fifo_addr_o, 32'h500);
    check("rg_push_data", fifo_rdata_o, 32'hBB);
    tick();
    bus(0, 0, 0);
    check("end_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
